flashing_light_axil_slave: RTL and testbench

AXI4-Lite responder for the flashing-light custom IP: accepts register writes and reads from the PS-side AXI master (or the AXI VIP master in simulation) and drives the board LEDs from those registers. Holds four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC, followed by a timer and LED pattern generator. Sits directly behind the IP's S00_AXI port, inside the packaged IP top.

---
 rtl/flashing_light_pkg.sv | 44 ++++
 rtl/flashing_light_core.sv | 91 +++++++++
 rtl/flashing_light_axil_slave.sv | 168 ++++++++++++++++
 tb/tb_flashing_light_axil_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/flashing_light_pkg.sv
// flashing_light_pkg
// Shared definitions for the flashing-light AXI4-Lite slave and its LED core.
// Contents: register offsets, register-select type and its decode helper,
// CTRL bit positions, AXI response codes, and the byte-strobe merge function.
package flashing_light_pkg;

    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_PERIOD  = 4'h4;
    localparam logic [3:0] ADDR_PATTERN = 4'h8;
    localparam logic [3:0] ADDR_SCRATCH = 4'hC;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;

    typedef enum logic [1:0] {
        RESP_OKAY = 2'b00
    } axi_resp_e;

    typedef logic [1:0] reg_sel_t;

    localparam reg_sel_t SEL_CTRL    = ADDR_CTRL[3:2];
    localparam reg_sel_t SEL_PERIOD  = ADDR_PERIOD[3:2];
    localparam reg_sel_t SEL_PATTERN = ADDR_PATTERN[3:2];
    localparam reg_sel_t SEL_SCRATCH = ADDR_SCRATCH[3:2];

    // Byte address bits [1:0] never take part in register selection.
    function automatic reg_sel_t addr_to_sel(input logic [3:0] addr);
        return addr[3:2];
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/flashing_light_core.sv
// flashing_light_core
// Step counter, blink phase and rotate image that drive the LEDs.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   en, mode    enable and mode (0 = blink, 1 = rotate)
//   period      clock cycles per LED step (0 behaves as 1)
//   pattern     LED image
//   reload      clear counter/phase and reload the rotate image
//   led         registered LED drive, active-high
//
// state     | meaning
// ----------+----------------------------------------------------
// idle      | en = 0: counter/phase at 0, image tracks pattern, led = 0
// counting  | en = 1: counter advancing toward max(period,1)-1
// step      | counter at terminal count: wrap, toggle phase, rotate image
//
// The configuration inputs carry the register values as they will be after
// the current edge, so the core's state always matches the register file
// that is visible after the same edge (including the write that is
// committing on it).
module flashing_light_core
    import flashing_light_pkg::*;
#(
    parameter int LED_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [31:0]          period,
    input  logic [LED_WIDTH-1:0] pattern,
    input  logic                 reload,
    output logic [LED_WIDTH-1:0] led
);

    logic [31:0]          cnt_q;
    logic                 phase_q;
    logic [LED_WIDTH-1:0] image_q;

    logic [31:0]          cnt_n;
    logic                 phase_n;
    logic [LED_WIDTH-1:0] image_n;
    logic [LED_WIDTH-1:0] led_n;
    logic [31:0]          terminal;
    logic [LED_WIDTH-1:0] image_rot;

    assign terminal  = (period == 32'd0) ? 32'd0 : period - 32'd1;
    // Shift form keeps the rotate valid for LED_WIDTH = 1.
    assign image_rot = (image_q << 1) | (image_q >> (LED_WIDTH - 1));

    always_comb begin
        cnt_n   = cnt_q;
        phase_n = phase_q;
        image_n = image_q;
        if (!en || reload) begin
            cnt_n   = 32'd0;
            phase_n = 1'b0;
            image_n = pattern;
        end else if (cnt_q == terminal) begin
            cnt_n   = 32'd0;
            phase_n = !phase_q;
            image_n = image_rot;
        end else begin
            cnt_n = cnt_q + 32'd1;
        end

        led_n = '0;
        if (en) begin
            if (mode) begin
                led_n = image_n;
            end else if (phase_n) begin
                led_n = pattern;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 32'd0;
            phase_q <= 1'b0;
            image_q <= '0;
            led     <= '0;
        end else begin
            cnt_q   <= cnt_n;
            phase_q <= phase_n;
            image_q <= image_n;
            led     <= led_n;
        end
    end

endmodule

// File: rtl/flashing_light_axil_slave.sv
// flashing_light_axil_slave
// AXI4-Lite slave with four 32-bit registers (CTRL, PERIOD, PATTERN, SCRATCH)
// driving an LED blink/rotate generator.
// Ports:
//   s00_axi_aclk / s00_axi_aresetn   clock, asynchronous active-low reset
//   s00_axi_aw* / s00_axi_w*         write address / data (accepted independently)
//   s00_axi_b*                       write response, always OKAY
//   s00_axi_ar* / s00_axi_r*         read address / data, always OKAY
//   led                              LED drive, active-high
module flashing_light_axil_slave
    import flashing_light_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_WIDTH          = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [LED_WIDTH-1:0]            led
);

    logic                            aw_held;
    logic                            w_held;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_q;

    logic [31:0] ctrl_q, period_q, pattern_q, scratch_q;
    logic [31:0] ctrl_next, period_next, pattern_next, scratch_next;

    logic                            aw_acc, w_acc, ar_acc, commit, reload;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
    reg_sel_t                        wr_sel;
    logic [31:0]                     rd_mux;

    assign s00_axi_awready = !aw_held && !s00_axi_bvalid;
    assign s00_axi_wready  = !w_held && !s00_axi_bvalid;
    assign s00_axi_arready = !s00_axi_rvalid;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_rresp   = RESP_OKAY;

    assign aw_acc = s00_axi_awvalid && s00_axi_awready;
    assign w_acc  = s00_axi_wvalid && s00_axi_wready;
    assign ar_acc = s00_axi_arvalid && s00_axi_arready;

    // A write commits on the edge where the later of AW/W is accepted; the
    // earlier one comes from its holding register.
    assign commit  = (aw_held || aw_acc) && (w_held || w_acc);
    assign wr_addr = aw_held ? aw_addr_q : s00_axi_awaddr;
    assign wr_data = w_held ? w_data_q : s00_axi_wdata;
    assign wr_strb = w_held ? w_strb_q : s00_axi_wstrb;
    assign wr_sel  = addr_to_sel(wr_addr);
    assign reload  = commit && (wr_sel != SEL_SCRATCH);

    always_comb begin
        ctrl_next    = ctrl_q;
        period_next  = period_q;
        pattern_next = pattern_q;
        scratch_next = scratch_q;
        if (commit) begin
            case (wr_sel)
                SEL_CTRL:    ctrl_next    = apply_wstrb(ctrl_q, wr_data, wr_strb);
                SEL_PERIOD:  period_next  = apply_wstrb(period_q, wr_data, wr_strb);
                SEL_PATTERN: pattern_next = apply_wstrb(pattern_q, wr_data, wr_strb);
                SEL_SCRATCH: scratch_next = apply_wstrb(scratch_q, wr_data, wr_strb);
            endcase
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (addr_to_sel(s00_axi_araddr))
            SEL_CTRL:    rd_mux = ctrl_q;
            SEL_PERIOD:  rd_mux = period_q;
            SEL_PATTERN: rd_mux = pattern_q;
            SEL_SCRATCH: rd_mux = scratch_q;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_addr_q      <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            s00_axi_bvalid <= 1'b0;
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= '0;
            ctrl_q         <= 32'd0;
            period_q       <= 32'd0;
            pattern_q      <= 32'd0;
            scratch_q      <= 32'd0;
        end else begin
            if (s00_axi_bvalid && s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
            if (commit) begin
                aw_held        <= 1'b0;
                w_held         <= 1'b0;
                s00_axi_bvalid <= 1'b1;
            end else begin
                if (aw_acc) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s00_axi_awaddr;
                end
                if (w_acc) begin
                    w_held   <= 1'b1;
                    w_data_q <= s00_axi_wdata;
                    w_strb_q <= s00_axi_wstrb;
                end
            end

            ctrl_q    <= ctrl_next;
            period_q  <= period_next;
            pattern_q <= pattern_next;
            scratch_q <= scratch_next;

            // rd_mux reads the pre-edge registers, so a same-cycle write to
            // the same register returns the old value.
            if (ar_acc) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_mux;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    flashing_light_core #(
        .LED_WIDTH (LED_WIDTH)
    ) u_core (
        .clk     (s00_axi_aclk),
        .rst_n   (s00_axi_aresetn),
        .en      (ctrl_next[CTRL_EN]),
        .mode    (ctrl_next[CTRL_MODE]),
        .period  (period_next),
        .pattern (pattern_next[LED_WIDTH-1:0]),
        .reload  (reload),
        .led     (led)
    );

    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, wr_addr, s00_axi_araddr,
                           ctrl_next, pattern_next};

endmodule

// File: tb/tb_flashing_light_axil_slave.sv
module tb_flashing_light_axil_slave;

    logic        clk;
    logic        aresetn;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  led;

    int errors = 0;
    int checks = 0;

    flashing_light_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .LED_WIDTH          (4)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .led             (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("wr_accept", {31'b0, awready && wready}, 32'h1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_bvalid_bresp", {29'b0, bvalid, bresp}, 32'h4);
        @(negedge clk);
        chk("wr_bvalid_clear", {31'b0, bvalid}, 32'h0);
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept", {31'b0, arready}, 32'h1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("rd_rvalid_rresp", {29'b0, rvalid, rresp}, 32'h4);
        chk("rd_data", rdata, exp);
        @(negedge clk);
        chk("rd_rvalid_clear", {31'b0, rvalid}, 32'h0);
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = 4'h0; awprot = 3'b0; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr = 4'h0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        // reset state
        chk("reset_ready_valid", {27'b0, awready, wready, arready, bvalid, rvalid}, 32'h1C);
        chk("reset_resp", {28'b0, bresp, rresp}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_led", {28'b0, led}, 32'h0);

        // basic write / readback of all four registers
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        axi_read(4'h0, 32'h1);
        axi_read(4'h4, 32'h2);
        axi_read(4'h8, 32'h3);
        axi_read(4'hC, 32'h4);

        // W two cycles ahead of AW, then B held off for three cycles
        @(negedge clk);
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        chk("w_early_b_aw_w", {29'b0, bvalid, awready, wready}, 32'h2);
        @(negedge clk);
        chk("w_early_wait", {29'b0, bvalid, awready, wready}, 32'h2);
        awaddr = 4'hC; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("bhold_b_aw_w", {29'b0, bvalid, awready, wready}, 32'h4);
        end
        bready = 1'b1;
        @(negedge clk);
        chk("bdone_b_aw_w", {29'b0, bvalid, awready, wready}, 32'h3);
        axi_read(4'hC, 32'hA5A5A5A5);

        // byte strobes
        axi_write(4'hC, 32'hFFFFFFFF, 4'hF);
        axi_write(4'hC, 32'h00000000, 4'b0101);
        axi_read(4'hC, 32'hFF00FF00);

        // same-cycle read and write of one register returns the old value
        @(negedge clk);
        awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b1; araddr = 4'hC; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rw_same_bvalid_rvalid", {30'b0, bvalid, rvalid}, 32'h3);
        chk("rw_same_old_data", rdata, 32'hFF00FF00);
        axi_read(4'hC, 32'h12345678);

        // blink: period 3, pattern 5 (edge k counted from the CTRL commit edge)
        axi_write(4'h8, 32'h5, 4'hF);
        axi_write(4'h4, 32'h3, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        for (int k = 2; k < 14; k++) begin
            @(negedge clk);
            chk("blink_led", {28'b0, led}, (((k / 3) % 2) != 0) ? 32'h5 : 32'h0);
        end

        // rotate: pattern 1, period 3
        axi_write(4'h8, 32'h1, 4'hF);
        axi_write(4'h0, 32'h3, 4'hF);
        for (int k = 2; k < 15; k++) begin
            @(negedge clk);
            chk("rotate_led", {28'b0, led}, 32'h1 << ((k / 3) % 4));
        end

        // period 0 behaves as 1: blink toggles every cycle
        axi_write(4'h8, 32'hF, 4'hF);
        axi_write(4'h4, 32'h0, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            chk("period0_led", {28'b0, led}, ((k % 2) != 0) ? 32'hF : 32'h0);
        end

        // async reset with B and R pending and LEDs lit (rotating 0xF is steady 0xF)
        axi_write(4'h0, 32'h3, 4'hF);
        @(negedge clk);
        awaddr = 4'hC; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b0; araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("prereset_bvalid_rvalid", {30'b0, bvalid, rvalid}, 32'h3);
        chk("prereset_led", {28'b0, led}, 32'hF);
        #2 aresetn = 1'b0;
        #1;
        chk("async_reset_bvalid_rvalid", {30'b0, bvalid, rvalid}, 32'h0);
        chk("async_reset_led", {28'b0, led}, 32'h0);
        @(negedge clk);
        aresetn = 1'b1; bready = 1'b1; rready = 1'b1;
        axi_read(4'h0, 32'h0);
        axi_read(4'h4, 32'h0);
        axi_read(4'h8, 32'h0);
        axi_read(4'hC, 32'h0);
        @(negedge clk);
        chk("post_reset_led", {28'b0, led}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
